// File: rtl/transpuesta_pkg.sv
// Shared constants and state encoding for the row-DCT to transpose-buffer stage.
package transpuesta_pkg;

   // Row and column length of the 32x32 transform.
   localparam int LANES = 32;

   // Counters must reach 32, so they need six bits.
   localparam int CNT_W = 6;

   // Default first-stage shift for 32x32 blocks of 8-bit video.
   localparam int SHIFT1_32 = 4;

   // FILL loads rows into the transpose buffer; DRAIN unloads columns from it.
   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/dct_round_sat.sv
// Per-lane rounding right shift with saturation to the output width.
module dct_round_sat
   import transpuesta_pkg::*;
#(
   parameter int IN_WIDTH  = 25,
   parameter int OUT_WIDTH = 21,
   parameter int SHIFT     = SHIFT1_32
) (
   input  logic [IN_WIDTH-1:0]  x,
   output logic [OUT_WIDTH-1:0] y
);

   // Saturation limits, held one bit wider than the input so the rounding add cannot overflow.
   localparam logic signed [IN_WIDTH:0] MAXV =
      {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [IN_WIDTH:0] MINV = ~MAXV;

   logic signed [IN_WIDTH:0] x_ext;
   logic signed [IN_WIDTH:0] shifted;

   assign x_ext = signed'({x[IN_WIDTH-1], x});

   // A zero shift passes the value straight through, with no rounding offset.
   generate
      if (SHIFT == 0) begin : g_pass
         assign shifted = x_ext;
      end else begin : g_round
         localparam logic [IN_WIDTH:0] RND = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
         logic signed [IN_WIDTH:0] sum;
         assign sum     = signed'(x_ext + RND);
         assign shifted = sum >>> SHIFT;
      end
   endgenerate

   // Clamp the shifted value into the signed range of the output lane.
   always_comb begin
      y = shifted[OUT_WIDTH-1:0];
      if (shifted > MAXV) begin
         y = MAXV[OUT_WIDTH-1:0];
      end else if (shifted < MINV) begin
         y = MINV[OUT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/transpuesta_ctrl.sv
// Scales first-stage DCT rows into the 32x32 transpose buffer, then sequences the column unloads.
// The buffer's active-high reset is expected to be driven externally with the inverse of rst.
module transpuesta_ctrl
   import transpuesta_pkg::*;
#(
   parameter int IN_WIDTH  = 25,
   parameter int OUT_WIDTH = 21,
   parameter int SHIFT     = SHIFT1_32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LANES*IN_WIDTH-1:0]  in_row,
   output logic [LANES*OUT_WIDTH-1:0] tr_x,
   output logic                       tr_load,
   output logic                       tr_unload,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_first,
   output logic                       out_last,
   output logic                       busy
);

   state_t                    state;
   state_t                    state_nxt;
   logic [CNT_W-1:0]          acc_cnt;
   logic [CNT_W-1:0]          ld_cnt;
   logic [CNT_W-1:0]          col_cnt;
   logic                      stg_valid;
   logic                      accept;
   logic                      last_load;
   logic                      last_unload;
   logic [LANES*OUT_WIDTH-1:0] scaled;

   // One rounding/saturation slice per lane.
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         dct_round_sat #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH),
            .SHIFT     (SHIFT)
         ) u_round_sat (
            .x (in_row[i*IN_WIDTH +: IN_WIDTH]),
            .y (scaled[i*OUT_WIDTH +: OUT_WIDTH])
         );
      end
   endgenerate

   assign accept      = in_valid && in_ready;
   assign last_load   = tr_load && (ld_cnt == CNT_W'(LANES - 1));
   assign last_unload = tr_unload && (col_cnt == CNT_W'(LANES - 1));

   // State register; a reset anywhere in a block simply discards it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Enter DRAIN once the 32nd row is captured, return to FILL after the 32nd column.
   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (last_load)   state_nxt = DRAIN;
         DRAIN:   if (last_unload) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // Handshake and strobe outputs decoded from state, counters and the row stage.
   always_comb begin
      in_ready  = rst && (state == FILL) && (acc_cnt < CNT_W'(LANES));
      tr_load   = stg_valid;
      tr_unload = (state == DRAIN) && out_ready;
      out_valid = (state == DRAIN);
      out_first = (state == DRAIN) && (col_cnt == '0);
      out_last  = (state == DRAIN) && (col_cnt == CNT_W'(LANES - 1));
      busy      = (state == DRAIN) || stg_valid;
   end

   // Accept, load and column counters for the current block.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_cnt <= '0;
         ld_cnt  <= '0;
         col_cnt <= '0;
      end else begin
         if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
         end
         if (last_load) begin
            acc_cnt <= '0;
         end
         if (tr_load) begin
            ld_cnt <= ld_cnt + CNT_W'(1);
         end
         if (tr_unload) begin
            col_cnt <= col_cnt + CNT_W'(1);
         end
         if (last_unload) begin
            col_cnt <= '0;
            ld_cnt  <= '0;
         end
      end
   end

   // Row stage: holds the scaled row for the single cycle the buffer needs to capture it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stg_valid <= 1'b0;
         tr_x      <= '0;
      end else begin
         stg_valid <= accept;
         if (accept) begin
            tr_x <= scaled;
         end
      end
   end

   // Loading and unloading the buffer in the same cycle would corrupt it.
   a_no_load_unload : assert property (@(posedge clk) disable iff (!rst) !(tr_load && tr_unload));

endmodule

// File: tb/tb_transpuesta_ctrl.sv
// Directed self-checking bench for transpuesta_ctrl with a small transpose-buffer model.
module tb_transpuesta_ctrl;

   localparam int IW = 25;
   localparam int OW = 21;
   localparam int NL = 32;

   typedef struct {
      logic signed [IW-1:0] x;
      logic signed [OW-1:0] y;
   } scale_vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [NL*IW-1:0]  in_row = '0;
   logic              in_ready;
   logic [NL*OW-1:0]  tr_x;
   logic              tr_load;
   logic              tr_unload;
   logic              out_valid;
   logic              out_first;
   logic              out_last;
   logic              busy;

   int checks = 0;
   int errors = 0;
   int n_load = 0;
   int n_unload = 0;
   int n_both = 0;
   int load_base = 0;

   logic signed [OW-1:0] mat [NL][NL];
   scale_vec_t vecs [12];

   transpuesta_ctrl #(
      .IN_WIDTH  (IW),
      .OUT_WIDTH (OW),
      .SHIFT     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_row    (in_row),
      .tr_x      (tr_x),
      .tr_load   (tr_load),
      .tr_unload (tr_unload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_first (out_first),
      .out_last  (out_last),
      .busy      (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [NL*IW-1:0] row);
      in_valid = v;
      in_row   = row;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Transpose buffer model: captures rows on load, checks column values on unload.
   always @(posedge clk) begin
      if (!rst) begin
         n_load   = 0;
         n_unload = 0;
      end else begin
         if (tr_load && tr_unload) n_both++;
         if (tr_load) begin
            for (int c = 0; c < NL; c++) mat[n_load % NL][c] = tr_x[c*OW +: OW];
            n_load++;
         end
         if (tr_unload) begin
            for (int j = 0; j < 3; j++) begin
               int i;
               int k;
               i = (j == 0) ? 0 : ((j == 1) ? 15 : 31);
               k = n_unload % NL;
               checkOutput($sformatf("col%0d_y%0d", k, i), longint'(mat[31-i][k]),
                           longint'(32 * (31 - i) + k));
            end
            n_unload++;
         end
      end
   end

   task automatic reset_dut();
      applyStimulus(1'b0, '0);
      out_ready = 1'b0;
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      #1;
   endtask

   task automatic fill_block(input logic hold_valid);
      logic [NL*IW-1:0] row;
      load_base = n_load;
      for (int r = 0; r < NL; r++) begin
         for (int c = 0; c < NL; c++) row[c*IW +: IW] = IW'(16 * (32 * r + c));
         applyStimulus(1'b1, row);
         #1;
         checkOutput($sformatf("in_ready_row%0d", r), longint'(in_ready), 1);
         tick();
      end
      in_valid = hold_valid;
      #1;
      checkOutput("in_ready_after_32", longint'(in_ready), 0);
      checkOutput("last_row_load", longint'(tr_load), 1);
      checkOutput("out_valid_before_drain", longint'(out_valid), 0);
   endtask

   task automatic drain_block(input int mode, input int stop_after);
      int cycles;
      int base;
      cycles = 0;
      base = n_unload;
      out_ready = 1'b1;
      tick();
      checkOutput("out_valid_rise", longint'(out_valid), 1);
      checkOutput("loads_in_block", longint'(n_load - load_base), 32);
      while (out_valid && (n_unload - base) < stop_after && cycles < 300) begin
         out_ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
         #1;
         checkOutput("tr_unload_vs_ready", longint'(tr_unload), longint'(out_ready));
         checkOutput("out_first", longint'(out_first), longint'((n_unload % NL) == 0));
         checkOutput("out_last", longint'(out_last), longint'((n_unload % NL) == 31));
         checkOutput("in_ready_in_drain", longint'(in_ready), 0);
         checkOutput("tr_load_in_drain", longint'(tr_load), 0);
         tick();
         cycles++;
      end
      checkOutput("unload_count", longint'(n_unload - base), longint'(stop_after));
      if (stop_after == 32) begin
         checkOutput("drain_cycles", longint'(cycles), (mode == 0) ? 32 : 94);
         out_ready = 1'b0;
         #1;
         checkOutput("out_valid_fall", longint'(out_valid), 0);
         checkOutput("in_ready_resume", longint'(in_ready), 1);
      end
   endtask

   // Watchdog so a stuck design still ends the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [NL*IW-1:0] row;

      vecs[0]  = '{x: 25'sd8,         y: 21'sd1};
      vecs[1]  = '{x: -25'sd8,        y: 21'sd0};
      vecs[2]  = '{x: 25'sd7,         y: 21'sd0};
      vecs[3]  = '{x: -25'sd9,        y: -21'sd1};
      vecs[4]  = '{x: 25'sd16777215,  y: 21'sd1048575};
      vecs[5]  = '{x: 25'h1000000,    y: 21'h100000};
      vecs[6]  = '{x: 25'sd0,         y: 21'sd0};
      vecs[7]  = '{x: 25'sd15,        y: 21'sd1};
      vecs[8]  = '{x: -25'sd25,       y: -21'sd2};
      vecs[9]  = '{x: 25'sd16777200,  y: 21'sd1048575};
      vecs[10] = '{x: -25'sd16777208, y: -21'sd1048575};
      vecs[11] = '{x: 25'sd16777208,  y: 21'sd1048575};

      // Reset held with in_valid high.
      rst = 1'b0;
      in_valid = 1'b1;
      repeat (3) tick();
      checkOutput("rst_in_ready", longint'(in_ready), 0);
      checkOutput("rst_tr_load", longint'(tr_load), 0);
      checkOutput("rst_tr_unload", longint'(tr_unload), 0);
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_out_first", longint'(out_first), 0);
      checkOutput("rst_out_last", longint'(out_last), 0);
      checkOutput("rst_busy", longint'(busy), 0);
      checkOutput("rst_tr_x_ones", longint'($countones(tr_x)), 0);
      rst = 1'b1;
      in_valid = 1'b0;
      tick();
      checkOutput("release_in_ready", longint'(in_ready), 1);

      // Scaling vectors, one per lane.
      row = '0;
      for (int v = 0; v < 12; v++) row[v*IW +: IW] = vecs[v].x;
      applyStimulus(1'b1, row);
      tick();
      in_valid = 1'b0;
      #1;
      checkOutput("scale_load_pulse", longint'(tr_load), 1);
      checkOutput("scale_busy", longint'(busy), 1);
      for (int v = 0; v < 12; v++) begin
         checkOutput($sformatf("scale_lane%0d", v), longint'($signed(tr_x[v*OW +: OW])),
                     longint'(vecs[v].y));
      end
      tick();
      checkOutput("scale_load_end", longint'(tr_load), 0);

      // Full block at full throughput.
      reset_dut();
      fill_block(1'b0);
      drain_block(0, 32);

      // Backpressure pattern 1,0,0 during the drain.
      fill_block(1'b0);
      drain_block(1, 32);

      // Reset after ten unloads, then a fresh block.
      fill_block(1'b0);
      drain_block(0, 10);
      rst = 1'b0;
      tick();
      checkOutput("midrst_out_valid", longint'(out_valid), 0);
      checkOutput("midrst_tr_unload", longint'(tr_unload), 0);
      checkOutput("midrst_in_ready", longint'(in_ready), 0);
      checkOutput("midrst_busy", longint'(busy), 0);
      rst = 1'b1;
      out_ready = 1'b0;
      #1;
      checkOutput("midrst_release_ready", longint'(in_ready), 1);
      fill_block(1'b0);
      drain_block(0, 32);

      // in_valid held through the drain.
      fill_block(1'b1);
      drain_block(0, 32);
      tick();
      checkOutput("resume_load", longint'(tr_load), 1);
      in_valid = 1'b0;
      checkOutput("load_unload_overlap", longint'(n_both), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
